fmc_regbank_sync: RTL and testbench

- Parametrised successor of the FPGA-side FMC bridge between the STM32 FMC (NOR/PSRAM, address/data multiplexed, 16-bit) and FPGA logic.
- All bus pins are synchronised into `clk`, and a state machine tracks address, write and read phases.
- Exposes NUM_CH STM32->FPGA registers, NUM_CH FPGA->STM32 inputs, and per-channel write and read strobes (for FIFO push/pop).
- Also provides base-address decode and protocol-error detection.

---
 rtl/fmc_regbank_sync_if.sv | 9 +
 rtl/fmc_regbank_sync.sv | 115 +++++++++++
 tb/tb_fmc_regbank_sync.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fmc_regbank_sync_if.sv
// fmc_regbank_sync_if: FMC control strobes from the STM32 (master) to the FPGA bridge (slave)
interface fmc_regbank_sync_if;
  logic fpga_nl_nadv;
  logic fpga_cs_ne1;
  logic fpga_wr_nwe;
  logic fpga_rd_noe;
  modport master (output fpga_nl_nadv, fpga_cs_ne1, fpga_wr_nwe, fpga_rd_noe);
  modport slave (input fpga_nl_nadv, fpga_cs_ne1, fpga_wr_nwe, fpga_rd_noe);
endinterface

// File: rtl/fmc_regbank_sync.sv
// fmc_regbank_sync: synchronised STM32 FMC muxed-bus bridge to a bank of per-channel registers
module fmc_regbank_sync #(
  parameter int NUM_CH = 16,
  parameter int ADDR_W = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int SYNC_STAGES = 2,
  parameter logic [15:0] RD_DEFAULT = 16'hDEAD
) (
  input logic clk,
  input logic rst,
  fmc_regbank_sync_if.slave bus,
  inout wire [15:0] fpga_db,
  input logic [NUM_CH*16-1:0] write_data,
  output logic [NUM_CH*16-1:0] read_data,
  output logic [NUM_CH-1:0] wr_pulse,
  output logic [NUM_CH-1:0] rd_pulse,
  output logic [ADDR_W-1:0] addr,
  output logic busy,
  output logic err_sticky
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int NADV = 3, CS = 2, NWE = 1, NOE = 0;
  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, WRITE, READ} state_t;
  state_t state;
  logic [3:0] ctl_q [SYNC_STAGES];
  logic [15:0] db_q [SYNC_STAGES];
  logic [3:0] ctl_s, ctl_d;
  logic [15:0] db_s, rd_data_reg;
  logic nadv_rise, nadv_fall, cs_rise, nwe_rise, nwe_fall, noe_rise, noe_fall;
  logic [16:0] off;
  logic in_rng;
  logic [IW-1:0] idx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctl_q[i] <= '1;
        db_q[i] <= '0;
      end
      ctl_d <= '1;
    end else begin
      ctl_q[0] <= {bus.fpga_nl_nadv, bus.fpga_cs_ne1, bus.fpga_wr_nwe, bus.fpga_rd_noe};
      db_q[0] <= fpga_db;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctl_q[i] <= ctl_q[i-1];
        db_q[i] <= db_q[i-1];
      end
      ctl_d <= ctl_q[SYNC_STAGES-1];
    end
  end
  assign ctl_s = ctl_q[SYNC_STAGES-1];
  assign db_s = db_q[SYNC_STAGES-1];
  assign nadv_rise = ctl_s[NADV] & ~ctl_d[NADV];
  assign nadv_fall = ~ctl_s[NADV] & ctl_d[NADV];
  assign cs_rise = ctl_s[CS] & ~ctl_d[CS];
  assign nwe_rise = ctl_s[NWE] & ~ctl_d[NWE];
  assign nwe_fall = ~ctl_s[NWE] & ctl_d[NWE];
  assign noe_rise = ctl_s[NOE] & ~ctl_d[NOE];
  assign noe_fall = ~ctl_s[NOE] & ctl_d[NOE];
  // borrow out of the subtraction means the address lies below the base
  assign off = 17'(addr) - {1'b0, BASE_ADDR};
  assign in_rng = !off[16] && off[15:0] < 16'(NUM_CH);
  assign idx = off[IW-1:0];
  assign busy = state != IDLE;
  assign fpga_db = (state == READ && !bus.fpga_rd_noe && !bus.fpga_cs_ne1) ? rd_data_reg : 'z;
  always_ff @(posedge clk) begin
    wr_pulse <= '0;
    rd_pulse <= '0;
    if (!rst) begin
      state <= IDLE;
      read_data <= '0;
      addr <= '0;
      rd_data_reg <= '0;
      err_sticky <= 1'b0;
    end else if (state == IDLE) begin
      if (!ctl_s[CS] && !ctl_s[NADV]) state <= ADDR;
    end else if (cs_rise) begin
      state <= IDLE;
    end else if (nadv_fall && !ctl_s[CS]) begin
      state <= ADDR;
    end else if (state != ADDR && !ctl_s[NWE] && !ctl_s[NOE]) begin
      err_sticky <= 1'b1;
      state <= ACCESS;
    end else begin
      case (state)
        ADDR: begin
          addr <= db_s[ADDR_W-1:0];
          if (nadv_rise) state <= ACCESS;
        end
        ACCESS: begin
          if (nwe_fall) state <= WRITE;
          else if (noe_fall) begin
            state <= READ;
            rd_data_reg <= in_rng ? write_data[16*idx +: 16] : RD_DEFAULT;
          end
        end
        WRITE: begin
          if (nwe_rise) begin
            state <= ACCESS;
            if (in_rng) begin
              read_data[16*idx +: 16] <= db_s;
              wr_pulse[idx] <= 1'b1;
            end else err_sticky <= 1'b1;
          end
        end
        READ: begin
          if (noe_rise) begin
            state <= ACCESS;
            if (in_rng) rd_pulse[idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmc_regbank_sync.sv
// tb_fmc_regbank_sync: directed plus randomized FMC transactions checked against a register-bank model
module tb_fmc_regbank_sync;
  localparam int S = 2, N = 16;
  localparam logic [15:0] BASE = 16'h0100, HIZ = 16'hFFFF;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  fmc_regbank_sync_if bus ();
  tri1 [15:0] fpga_db;
  logic drv = 1'b0;
  logic [15:0] drv_val = '0;
  assign fpga_db = drv ? drv_val : 'z;
  logic [N*16-1:0] write_data = '0, read_data;
  logic [N-1:0] wr_pulse, rd_pulse;
  logic [15:0] addr;
  logic busy, err_sticky;
  logic [15:0] regs [N];
  logic err_m;
  int errors = 0, checks = 0;
  fmc_regbank_sync #(.NUM_CH(N), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fpga_db(fpga_db), .write_data(write_data),
    .read_data(read_data), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse), .addr(addr),
    .busy(busy), .err_sticky(err_sticky)
  );
  task automatic chk(input string tag, input logic [N*16-1:0] got, input logic [N*16-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic bit in_range(input logic [15:0] a);
    return int'(a) >= int'(BASE) && int'(a) - int'(BASE) < N;
  endfunction
  function automatic logic [N-1:0] exp_pulse(input logic [15:0] a);
    logic [N-1:0] p = '0;
    if (in_range(a)) p[int'(a) - int'(BASE)] = 1'b1;
    return p;
  endfunction
  function automatic logic [N*16-1:0] model_vec();
    logic [N*16-1:0] v;
    for (int k = 0; k < N; k++) v[16*k +: 16] = regs[k];
    return v;
  endfunction
  task automatic rst_check();
    for (int k = 0; k < N; k++) regs[k] = '0;
    err_m = 1'b0;
    chk("rst_read_data", read_data, model_vec());
    chk("rst_addr", addr, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_rd_pulse", rd_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_db_hiz", fpga_db, HIZ);
  endtask
  task automatic addr_phase(input logic [15:0] a);
    bus.fpga_cs_ne1 = 1'b0;
    bus.fpga_nl_nadv = 1'b0;
    drv = 1'b1;
    drv_val = a;
    step(S + 3);
    bus.fpga_nl_nadv = 1'b1;
    step(S + 2);
    drv = 1'b0;
    chk("addr", addr, a);
    chk("busy", busy, 1);
  endtask
  task automatic end_cs();
    bus.fpga_cs_ne1 = 1'b1;
    step(S + 2);
    chk("busy_idle", busy, 0);
  endtask
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    addr_phase(a);
    drv = 1'b1;
    drv_val = d;
    bus.fpga_wr_nwe = 1'b0;
    step(S + 3);
    bus.fpga_wr_nwe = 1'b1;
    for (int i = 1; i <= S + 2; i++) begin
      step(1);
      chk("wr_pulse", wr_pulse, i == S + 1 ? exp_pulse(a) : '0);
    end
    drv = 1'b0;
    if (in_range(a)) regs[int'(a) - int'(BASE)] = d;
    else err_m = 1'b1;
    chk("read_data", read_data, model_vec());
    chk("err_sticky", err_sticky, err_m);
  endtask
  task automatic do_read(input logic [15:0] a);
    logic [15:0] exp_d;
    exp_d = in_range(a) ? write_data[16*(int'(a) - int'(BASE)) +: 16] : 16'hDEAD;
    addr_phase(a);
    bus.fpga_rd_noe = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i != S + 1) chk("db_read", fpga_db, i > S ? exp_d : HIZ);
      chk("rd_pulse_low", rd_pulse, 0);
    end
    bus.fpga_rd_noe = 1'b1;
    for (int i = 1; i <= S + 2; i++) begin
      step(1);
      chk("db_hiz", fpga_db, HIZ);
      chk("rd_pulse", rd_pulse, i == S + 1 ? exp_pulse(a) : '0);
    end
    chk("err_after_read", err_sticky, err_m);
  endtask
  initial begin
    logic [15:0] a;
    bus.fpga_nl_nadv = 1'b1;
    bus.fpga_cs_ne1 = 1'b1;
    bus.fpga_wr_nwe = 1'b1;
    bus.fpga_rd_noe = 1'b1;
    step(2);
    rst_check();
    rst = 1'b1;
    step(2);
    do_write(16'h0103, 16'hA55A);
    end_cs();
    write_data[16*15 +: 16] = 16'h1234;
    do_read(16'h010F);
    end_cs();
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) write_data[16*k +: 16] = 16'($urandom_range(0, 16'hFFFE));
      a = BASE + 16'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom_range(0, 16'hFFFE)));
      else do_read(a);
      end_cs();
    end
    // chip select drops away mid-write: nothing may land
    addr_phase(16'h0105);
    drv = 1'b1;
    drv_val = 16'hBEEF;
    bus.fpga_wr_nwe = 1'b0;
    step(S + 3);
    bus.fpga_cs_ne1 = 1'b1;
    step(S + 2);
    chk("abort_busy", busy, 0);
    bus.fpga_wr_nwe = 1'b1;
    drv = 1'b0;
    for (int i = 0; i < S + 3; i++) begin
      step(1);
      chk("abort_wr_pulse", wr_pulse, 0);
    end
    chk("abort_read_data", read_data, model_vec());
    do_write(16'h0100, 16'h0001);
    do_write(16'h0101, 16'h0002);
    end_cs();
    do_write(16'h0110, 16'h7777);
    end_cs();
    do_read(16'h00FF);
    end_cs();
    addr_phase(16'h0102);
    drv = 1'b1;
    drv_val = 16'h5A5A;
    bus.fpga_wr_nwe = 1'b0;
    step(S + 3);
    rst = 1'b0;
    drv = 1'b0;
    step(1);
    rst_check();
    rst = 1'b1;
    bus.fpga_wr_nwe = 1'b1;
    bus.fpga_cs_ne1 = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      step(1);
      chk("post_rst_wr_pulse", wr_pulse, 0);
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_read_data", read_data, model_vec());
    addr_phase(16'h0104);
    bus.fpga_wr_nwe = 1'b0;
    bus.fpga_rd_noe = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      step(1);
      chk("proto_db_hiz", fpga_db, HIZ);
      chk("proto_wr_pulse", wr_pulse, 0);
      chk("proto_rd_pulse", rd_pulse, 0);
    end
    chk("proto_err", err_sticky, 1);
    bus.fpga_wr_nwe = 1'b1;
    bus.fpga_rd_noe = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      step(1);
      chk("proto_release_wr", wr_pulse, 0);
      chk("proto_release_rd", rd_pulse, 0);
    end
    end_cs();
    chk("proto_read_data", read_data, model_vec());
    chk("proto_err_sticky", err_sticky, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
